ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage consumer of ID/EX outputs: iterative 32-bit multiply/divide unit writing HI/LO.
//  Takes RD1/RD2 and a mul/div op from the ID/EX register, runs one shift-add or
//  restoring-divide step per cycle, and drives a stall back to PC, IF/ID and ID/EX.
//  The op stays frozen in EX until the result is committed; HI/LO feed MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST        in   1      asynchronous, active-high reset
//  start      in   1      ID/EX holds a mul/div op this cycle
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  flush      in   1      branch-taken flush of EX; aborts the operation
//  RD1        in   WIDTH  rs operand (multiplicand / dividend)
//  RD2        in   WIDTH  rt operand (multiplier / divisor)
//  stall      out  1      freeze PC, IF/ID, ID/EX this cycle
//  done       out  1      one-cycle pulse: HI/LO just updated
//  HI         out  WIDTH  product[63:32] / remainder
//  LO         out  WIDTH  product[31:0] / quotient
// BEHAVIOUR
//  Reset: state IDLE, count 0, HI=0, LO=0, done=0, stall=0; internal regs 0.
//  FSM IDLE -> BUSY -> FIX -> IDLE.
//  IDLE: accept when start & ~flush & ~done; latch op, |RD1|, |RD2| (magnitudes for
//   signed ops), result signs; count=0; go BUSY. start is ignored while done=1 (op leaving EX).
//  BUSY: one iteration per cycle; count 0..WIDTH-1; after count==WIDTH-1 go FIX.
//   MUL: 2*WIDTH-bit shift-add on magnitudes. DIV: restoring, WIDTH-bit quotient/remainder.
//  FIX: apply sign (two's-complement negate); register HI/LO at the FIX->IDLE edge; done=1
//   for the following IDLE cycle only.
//  stall (combinational) = (IDLE & start & ~flush & ~done) | BUSY | FIX.
//  Latency: accept cycle + WIDTH BUSY + 1 FIX = WIDTH+2 stall cycles; result valid
//   (done=1) in cycle WIDTH+2 after accept.
//  Signed rules: MULT product sign = sA^sB. DIV quotient truncates toward zero,
//   remainder sign = dividend sign. -2^31 / -1 -> LO=0x80000000, HI=0 (no trap).
//  Divide by zero (DIV, DIVU): LO=all ones, HI=RD1 unchanged; still takes full latency.
//  flush in BUSY or FIX: next state IDLE, HI/LO unchanged, done stays 0, stall drops next cycle.
//  start during BUSY/FIX: ignored (op held frozen by stall).
//  RST asserted mid-operation: immediate return to reset values; no partial HI/LO write.
//  HI/LO change only at FIX->IDLE edge or reset.
// STRUCTURE
//  Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings
//   (S_IDLE, S_BUSY, S_FIX), count width = $clog2(WIDTH).
//  Sub-module muldiv_step: combinational single iteration (add-shift or trial-subtract),
//   instantiated once; FSM, counters, sign fix and HI/LO registers stay in top.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 stall cycles HI=0xFFFFFFFE, LO=0x00000001, done 1 cycle.
//  MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; start held high through done -> no restart.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064; DIVU 100/7 -> LO=14, HI=2.
//  HI/LO=preset, flush at BUSY count 10 -> IDLE next cycle, HI/LO unchanged, done never set.
//  RST pulse mid-BUSY (async, between edges) -> stall=0, HI=LO=0 immediately; new op runs clean.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef logic [1:0] md_op_t;

    function automatic logic op_is_div(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side connection of the multiply/divide unit: op request, stall back-pressure, HI/LO.
interface ex_muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_t           op;
    logic             flush;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, flush, RD1, RD2,
        input  stall, done, HI, LO
    );

    modport slave (
        input  start, op, flush, RD1, RD2,
        output stall, done, HI, LO
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step
// on the {hi, lo} working pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, product bits enter from the top.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        // Divide: partial remainder is always below the divisor, so the difference fits WIDTH bits.
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                hi_nxt = diff;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit: one step per cycle on magnitudes,
// sign fix in a final cycle, HI/LO committed on the FIX->IDLE edge.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic              CLK,
    input logic              RST,
    ex_muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] count_q;
    logic             div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] hi_acc_q;
    logic [WIDTH-1:0] lo_acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             accept;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign accept = (state_q == S_IDLE) & bus.start & ~bus.flush & ~done_q;
    assign sa     = op_is_signed(bus.op) & bus.RD1[WIDTH-1];
    assign sb     = op_is_signed(bus.op) & bus.RD2[WIDTH-1];

    assign bus.stall = accept | (state_q == S_BUSY) | (state_q == S_FIX);
    assign bus.done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (div_q),
        .hi      (hi_acc_q),
        .lo      (lo_acc_q),
        .operand (operand_q),
        .hi_nxt  (step_hi),
        .lo_nxt  (step_lo)
    );

    always_comb begin
        fix_hi = hi_acc_q;
        fix_lo = lo_acc_q;
        if (div_q) begin
            fix_lo = neg_if(lo_acc_q, neg_lo_q);
            fix_hi = neg_if(hi_acc_q, neg_hi_q);
        end else begin
            {fix_hi, fix_lo} = neg_wide_if({hi_acc_q, lo_acc_q}, neg_lo_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            div_q     <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            operand_q <= '0;
            hi_acc_q  <= '0;
            lo_acc_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        div_q     <= op_is_div(bus.op);
                        // A zero divisor keeps the quotient at all ones regardless of signs.
                        neg_lo_q  <= (sa ^ sb) & ~(op_is_div(bus.op) & (bus.RD2 == '0));
                        neg_hi_q  <= sa;
                        operand_q <= neg_if(bus.RD2, sb);
                        lo_acc_q  <= neg_if(bus.RD1, sa);
                        hi_acc_q  <= '0;
                        count_q   <= '0;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_acc_q <= step_hi;
                        lo_acc_q <= step_lo;
                        count_q  <= count_q + CNT_W'(1);
                        if (count_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
